alu_seq_core: RTL
=================

// Module: alu_seq_core
// PURPOSE
//  Parametrised sequential ALU core; successor to the fixed 8-bit TinyTapeout ALU.
//  Accepts one operation per valid/ready handshake and returns result plus flags on an output handshake.
//  Single-cycle logic/arith ops; multi-cycle shift-add MUL and restoring DIV.
//  Sits between the tt_um pin-mapping wrapper and the operand/result registers.
// PARAMETERS
//  WIDTH   8   operand/result width in bits; >=4. SW = $clog2(WIDTH) is the shift-amount width.
// PORTS
//  clk        in   1      clock; all state updates on rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operation request valid
//  in_ready   out  1      core can accept a request (state==IDLE)
//  op         in   4      opcode, see BEHAVIOUR
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B (shift ops use b[SW-1:0])
//  out_valid  out  1      result/flags valid
//  out_ready  in   1      consumer takes the result
//  result     out  WIDTH  primary result (MUL low half, DIV quotient)
//  result_hi  out  WIDTH  MUL high half / DIV remainder; 0 for other ops
//  flags      out  4      {Z,N,C,V}
//  err        out  1      illegal opcode flagged with the result
// BEHAVIOUR
//  Reset: state=IDLE; result, result_hi, flags, err, out_valid = 0; in_ready=1. Async assert aborts any op.
//  Accept when in_valid && in_ready: a, b, op captured that edge.
//  FSM states:
//   - IDLE->DONE for single-cycle ops: out_valid 1 cycle after accept.
//   - IDLE->EXEC for MUL/DIV. EXEC runs WIDTH iterations, then ->DONE: out_valid WIDTH+1 cycles after accept.
//   - DONE: outputs held stable while out_ready=0. DONE && out_ready -> IDLE. in_ready=0 in EXEC/DONE.
//  Opcodes:
//   0 ADD; 1 SUB (a-b); 2 AND; 3 OR; 4 XOR; 5 NOT a;
//   6 SHL; 7 SHR (logical); 8 ASR;
//   9 CMP (SUB flags, result=0); 10 MUL unsigned; 11 DIV unsigned; 12-15 illegal.
//  Flags: Z=(result==0), except MUL, where Z is taken over the full 2*WIDTH product. N=result[WIDTH-1].
//   - ADD: C=carry out; V=signed overflow.
//   - SUB/CMP: C=1 iff a>=b unsigned (no borrow); V=signed overflow.
//   - Shifts: C=last bit shifted out, 0 when amount=0; V=0.
//   - Logic ops: C=V=0.
//   - MUL: N=0; C=V=(result_hi!=0).
//   - DIV: N=C=0; V=1 on divide-by-zero.
//  Divide-by-zero: quotient all ones, remainder = a, completes in normal latency.
//  Illegal op: result=0, result_hi=0, flags={1,0,0,0}, err=1, single-cycle latency.
//  Arithmetic is mod 2^WIDTH; MUL product exact in {result_hi,result}.
// CONFIGURATION
//  ALU_DIV_EN defined:
//   - DIV datapath (restoring, 1 quotient bit/cycle) is compiled in; op 11 behaves as above.
//  ALU_DIV_EN undefined:
//   - no divider logic; op 11 is treated as illegal (err=1, result 0, 1-cycle latency).
// TESTING (WIDTH=8)
//  1. ADD a=0xFF b=0x01 -> result=0x00, flags Z=1 N=0 C=1 V=0, out_valid exactly 1 cycle after accept.
//  2. SUB a=0x80 b=0x01 -> result=0x7F, C=1 V=1; CMP a=0x03 b=0x05 -> result=0x00, C=0 N=1.
//  3. MUL a=0xFF b=0xFF -> result=0x01, result_hi=0xFE, C=V=1, out_valid 9 cycles after accept.
//  4. DIV 100/7 -> result=14, result_hi=2. DIV a=0x55 b=0 -> result=0xFF, result_hi=0x55, V=1.
//     Without ALU_DIV_EN: op 11 -> err=1, result=0.
//  5. Backpressure: out_ready=0 for 5 cycles after SHL a=0x81 b=1 -> result=0x02, C=1, held stable, in_ready=0.
//     Then out_ready=1 -> IDLE next cycle.
//  6. rst pulsed mid-MUL (cycle 4) -> out_valid=0, in_ready=1 after release; following ADD 2+3 returns 5.

Source files
------------

// File: rtl/alu_seq_core.sv
// Sequential ALU core: single-cycle logic/arith/shift ops, multi-cycle shift-add MUL and restoring DIV.
// Define ALU_DIV_EN to build the divider; without it, opcode 11 is reported as illegal.
module alu_seq_core #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       flags,
  output logic             err
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OpAdd = 4'd0;
  localparam logic [3:0] OpSub = 4'd1;
  localparam logic [3:0] OpAnd = 4'd2;
  localparam logic [3:0] OpOr  = 4'd3;
  localparam logic [3:0] OpXor = 4'd4;
  localparam logic [3:0] OpNot = 4'd5;
  localparam logic [3:0] OpShl = 4'd6;
  localparam logic [3:0] OpShr = 4'd7;
  localparam logic [3:0] OpAsr = 4'd8;
  localparam logic [3:0] OpCmp = 4'd9;
  localparam logic [3:0] OpMul = 4'd10;
  localparam logic [3:0] OpDiv = 4'd11;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, operand_q;
  logic [CW-1:0]    cnt_q;

  // Single-cycle datapath
  logic [WIDTH:0]   sum_ext, diff_ext, shl_ext, shr_ext, asr_ext;
  logic [SW-1:0]    amt;
  logic [WIDTH-1:0] s_res, s_fval;
  logic             s_c, s_v, s_err, s_multi;
  logic [3:0]       s_flags;

  assign amt      = b[SW-1:0];
  assign in_ready = (state_q == StIdle);

  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
    // Operands extended by one bit so the last bit shifted out lands in the spare position.
    shl_ext  = {1'b0, a} << amt;
    shr_ext  = {a, 1'b0} >> amt;
    asr_ext  = $signed({a, 1'b0}) >>> amt;
    s_res    = '0;
    s_fval   = '0;
    s_c      = 1'b0;
    s_v      = 1'b0;
    s_err    = 1'b0;
    s_multi  = 1'b0;
    case (op)
      OpAdd: begin
        s_res  = sum_ext[WIDTH-1:0];
        s_fval = s_res;
        s_c    = sum_ext[WIDTH];
        s_v    = (a[WIDTH-1] == b[WIDTH-1]) && (s_res[WIDTH-1] != a[WIDTH-1]);
      end
      OpSub, OpCmp: begin
        s_fval = diff_ext[WIDTH-1:0];
        s_res  = (op == OpCmp) ? '0 : s_fval;
        s_c    = ~diff_ext[WIDTH];
        s_v    = (a[WIDTH-1] != b[WIDTH-1]) && (s_fval[WIDTH-1] != a[WIDTH-1]);
      end
      OpAnd: begin
        s_res  = a & b;
        s_fval = s_res;
      end
      OpOr: begin
        s_res  = a | b;
        s_fval = s_res;
      end
      OpXor: begin
        s_res  = a ^ b;
        s_fval = s_res;
      end
      OpNot: begin
        s_res  = ~a;
        s_fval = s_res;
      end
      OpShl: begin
        s_res  = shl_ext[WIDTH-1:0];
        s_fval = s_res;
        s_c    = shl_ext[WIDTH];
      end
      OpShr: begin
        s_res  = shr_ext[WIDTH:1];
        s_fval = s_res;
        s_c    = shr_ext[0];
      end
      OpAsr: begin
        s_res  = asr_ext[WIDTH:1];
        s_fval = s_res;
        s_c    = asr_ext[0];
      end
      OpMul: s_multi = 1'b1;
`ifdef ALU_DIV_EN
      OpDiv: s_multi = 1'b1;
`else
      OpDiv: s_err = 1'b1;
`endif
      default: s_err = 1'b1;
    endcase
    s_flags = {(s_fval == '0), s_fval[WIDTH-1], s_c, s_v};
  end

  // Multi-cycle iteration step; acc_hi/acc_lo hold product halves or remainder/quotient.
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [3:0]       m_flags;
`ifdef ALU_DIV_EN
  logic [WIDTH:0]   rem_sh;
  logic             is_div_q;
`endif

  always_comb begin
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, operand_q} : '0);
    step_hi = mul_sum[WIDTH:1];
    step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    m_flags = {({step_hi, step_lo} == '0), 1'b0, (step_hi != '0), (step_hi != '0)};
`ifdef ALU_DIV_EN
    rem_sh = {acc_hi_q, acc_lo_q[WIDTH-1]};
    if (is_div_q) begin
      // Remainder stays below the divisor, so the difference always fits in WIDTH bits.
      if (rem_sh >= {1'b0, operand_q}) begin
        step_hi = rem_sh[WIDTH-1:0] - operand_q;
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b1};
      end else begin
        step_hi = rem_sh[WIDTH-1:0];
        step_lo = {acc_lo_q[WIDTH-2:0], 1'b0};
      end
      m_flags = {(step_lo == '0), 1'b0, 1'b0, (operand_q == '0)};
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      operand_q <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
      err       <= 1'b0;
`ifdef ALU_DIV_EN
      is_div_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (s_multi) begin
              state_q   <= StExec;
              acc_hi_q  <= '0;
              acc_lo_q  <= a;
              operand_q <= b;
              cnt_q     <= CW'(WIDTH - 1);
`ifdef ALU_DIV_EN
              is_div_q  <= (op == OpDiv);
`endif
            end else begin
              state_q   <= StDone;
              out_valid <= 1'b1;
              result    <= s_res;
              result_hi <= '0;
              flags     <= s_flags;
              err       <= s_err;
            end
          end
        end
        StExec: begin
          acc_hi_q <= step_hi;
          acc_lo_q <= step_lo;
          cnt_q    <= cnt_q - 1'b1;
          if (cnt_q == '0) begin
            state_q   <= StDone;
            out_valid <= 1'b1;
            result    <= step_lo;
            result_hi <= step_hi;
            flags     <= m_flags;
            err       <= 1'b0;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q   <= StIdle;
            out_valid <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
